unified_mem_arbiter: RTL

//  Arbitrates one single-ported unified memory between the IF stage (instruction fetch)
//  and the MEM stage (load/store) of the pipelined CPU. Sequences each access with a
//  req/ready handshake and drives a pipeline stall while any request is outstanding.

---
 rtl/unified_mem_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// Single-ported unified memory arbiter between the IF and MEM pipeline stages.
// DM wins contention, except when IF has been passed over STARVE_MAX times in a row.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    // Handshake: each requester holds req high until it sees its one-cycle ack;
    // the memory side holds mem_req_o until mem_ready_i, whose data is valid that cycle.
    logic [1:0]    state;
    logic          owner_dm;
    logic [SW-1:0] starve_cnt;
    logic          grant_dm;
    logic          grant_if;

    assign grant_dm  = (state == IDLE) && dm_req_i && (starve_cnt < SW'(STARVE_MAX));
    assign grant_if  = (state == IDLE) && !grant_dm && if_req_i;

    assign mem_req_o = (state == BUSY);
    assign if_ack_o  = (state == ACK) && !owner_dm;
    assign dm_ack_o  = (state == ACK) && owner_dm;
    assign stall_o   = (if_req_i && !if_ack_o) || (dm_req_i && !dm_ack_o);

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state       <= IDLE;
            owner_dm    <= 1'b0;
            starve_cnt  <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state       <= BUSY;
                        owner_dm    <= 1'b1;
                        mem_we_o    <= dm_we_i;
                        mem_addr_o  <= dm_addr_i;
                        mem_wdata_o <= dm_wdata_i;
                        // Only DM grants that leave IF waiting count toward starvation.
                        starve_cnt  <= if_req_i ? starve_cnt + SW'(1) : '0;
                    end else if (grant_if) begin
                        state       <= BUSY;
                        owner_dm    <= 1'b0;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= '0;
                        starve_cnt  <= '0;
                    end
                end
                BUSY: begin
                    if (mem_ready_i) begin
                        state <= ACK;
                        if (!owner_dm) begin
                            if_rdata_o <= mem_rdata_i;
                        end else if (!mem_we_o) begin
                            dm_rdata_o <= mem_rdata_i;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end
endmodule
